// File: rtl/demux_widen_param_pkg.sv
// -----------------------------------------------------------------------------
// demux_widen_param_pkg
// Shared constants and helpers for the clk_4f lane widener and its output
// holding register.
//   DEF_IN_W / DEF_RATIO : default beat width and beats per output word
//   ST_EMPTY / ST_FULL   : holding-register state encodings
//   laneCntWidth()       : width of a lane counter that spans 0..ratio-1
//   physSlot()           : logical lane -> physical slot of the output word
// -----------------------------------------------------------------------------
package demux_widen_param_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_RATIO = 4;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // A ratio of 2 still needs a one-bit counter, which $clog2 alone
    // would not guarantee for smaller values.
    function automatic int laneCntWidth(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    function automatic int physSlot(input int lane, input int ratio, input bit msbFirst);
        return msbFirst ? (ratio - 1 - lane) : lane;
    endfunction

endpackage

// File: rtl/demux_widen_param_if.sv
// -----------------------------------------------------------------------------
// demux_widen_param_if
// Beat input and word output bundle of the lane widener.
//   data_in   [IN_W]       input beat
//   valid_in               beat qualifier
//   out_ready              downstream accepts data_out this cycle
//   data_out  [IN_W*RATIO] assembled word
//   valid_out              a word is held awaiting acceptance
//   keep_out  [RATIO]      per-lane valid mask of the held word
//   overflow               one-cycle pulse when a completed word is dropped
// Modports: slave = widener side, master = beat source / word sink side.
// -----------------------------------------------------------------------------
interface demux_widen_param_if
    import demux_widen_param_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int RATIO = DEF_RATIO
);

    logic [IN_W-1:0]       data_in;
    logic                  valid_in;
    logic                  out_ready;
    logic [IN_W*RATIO-1:0] data_out;
    logic                  valid_out;
    logic [RATIO-1:0]      keep_out;
    logic                  overflow;

    modport slave (
        input  data_in, valid_in, out_ready,
        output data_out, valid_out, keep_out, overflow
    );

    modport master (
        output data_in, valid_in, out_ready,
        input  data_out, valid_out, keep_out, overflow
    );

endinterface

// File: rtl/demux_widen_param_out_hold_reg.sv
// -----------------------------------------------------------------------------
// out_hold_reg
// One-deep valid/ready holding register. A load is accepted when the register
// is empty or is being emptied on the same edge; a load arriving while the
// held word is stalled is dropped and reported with a one-cycle overflow
// pulse. Also intended for the mux_32_8 return path.
//   clk_4f      clock, posedge
//   reset       synchronous, active-low
//   i_load      a new word is offered this cycle
//   i_loadData  the offered word
//   i_ready     downstream accepts o_data this cycle
//   o_data      held word
//   o_valid     o_data holds a word awaiting acceptance
//   o_overflow  one-cycle pulse: an offered word was dropped
// -----------------------------------------------------------------------------
module out_hold_reg
    import demux_widen_param_pkg::*;
#(
    parameter int W = 8
)
(
    input  logic         clk_4f,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_loadData,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_overflow
);

    logic [0:0]   r_state;
    logic [W-1:0] r_data;
    logic         r_overflow;

    logic w_transfer;
    logic w_accept;
    logic w_drop;

    assign w_transfer = (r_state == ST_FULL) && i_ready;
    assign w_accept   = i_load && ((r_state == ST_EMPTY) || i_ready);
    assign w_drop     = i_load && (r_state == ST_FULL) && !i_ready;

    // Data is only written on an accepted load, so the held word stays
    // stable for as long as downstream stalls.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_accept) begin
                r_data  <= i_loadData;
                r_state <= ST_FULL;
            end else if (w_transfer) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign o_data     = r_data;
    assign o_valid    = (r_state == ST_FULL);
    assign o_overflow = r_overflow;

endmodule

// File: rtl/demux_widen_param.sv
// -----------------------------------------------------------------------------
// demux_widen_param
// Serial-to-parallel lane widener for the PCI physical-layer datapath.
// Collects RATIO consecutive IN_W-bit beats into one word, optionally flushes
// a partial word when valid_in drops mid-word, and hands words to a one-deep
// ready/valid holding register.
//   clk_4f   clock, posedge
//   reset    synchronous, active-low
//   bus      demux_widen_param_if.slave (beats in, words/keep/overflow out)
// Parameters: IN_W beat width, RATIO beats per word (2..16), MSB_FIRST puts
// the first beat in the top lane, FLUSH_PARTIAL emits partial words instead
// of discarding them. keep_out bits are indexed by physical lane of data_out.
// -----------------------------------------------------------------------------
module demux_widen_param
    import demux_widen_param_pkg::*;
#(
    parameter int IN_W          = DEF_IN_W,
    parameter int RATIO         = DEF_RATIO,
    parameter bit MSB_FIRST     = 1'b0,
    parameter bit FLUSH_PARTIAL = 1'b1
)
(
    input logic                clk_4f,
    input logic                reset,
    demux_widen_param_if.slave bus
);

    localparam int            LW        = laneCntWidth(RATIO);
    localparam int            OUT_W     = IN_W * RATIO;
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [LW-1:0]          r_lane;
    logic [OUT_W-1:0]       r_asm;

    logic [OUT_W-1:0]       w_asmNext;
    logic [RATIO-1:0]       w_partKeep;
    logic                   w_complete;
    logic                   w_flush;
    logic                   w_load;
    logic [RATIO+OUT_W-1:0] w_loadWord;
    logic [RATIO+OUT_W-1:0] w_holdWord;

    // Assembly register with the current beat merged in, and the keep mask
    // of the lanes already filled (used only when flushing a partial word).
    always_comb begin
        w_asmNext  = r_asm;
        w_partKeep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (r_lane == LW'(i)) begin
                w_asmNext[physSlot(i, RATIO, MSB_FIRST)*IN_W +: IN_W] = bus.data_in;
            end
            if (LW'(i) < r_lane) begin
                w_partKeep[physSlot(i, RATIO, MSB_FIRST)] = 1'b1;
            end
        end
    end

    assign w_complete = bus.valid_in && (r_lane == LAST_LANE);
    assign w_flush    = !bus.valid_in && (r_lane != '0);
    assign w_load     = w_complete || (w_flush && FLUSH_PARTIAL);
    assign w_loadWord = w_complete ? {{RATIO{1'b1}}, w_asmNext} : {w_partKeep, r_asm};

    // The assembly register is cleared whenever a word leaves it, so lanes
    // not written by a partial word read back as zero.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_lane <= '0;
            r_asm  <= '0;
        end else if (w_complete || w_flush) begin
            r_lane <= '0;
            r_asm  <= '0;
        end else if (bus.valid_in) begin
            r_lane <= r_lane + LW'(1);
            r_asm  <= w_asmNext;
        end
    end

    out_hold_reg #(
        .W (RATIO + OUT_W)
    ) u_hold (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .i_load     (w_load),
        .i_loadData (w_loadWord),
        .i_ready    (bus.out_ready),
        .o_data     (w_holdWord),
        .o_valid    (bus.valid_out),
        .o_overflow (bus.overflow)
    );

    assign bus.keep_out = w_holdWord[RATIO+OUT_W-1 -: RATIO];
    assign bus.data_out = w_holdWord[OUT_W-1:0];

endmodule

// File: tb/tb_demux_widen_param.sv
// -----------------------------------------------------------------------------
// tb_demux_widen_param
// Drives four widener configurations: 8x4 LSB-first with flush, 8x4 MSB-first
// with flush, 8x4 LSB-first discarding partials, and 16x2 LSB-first with
// flush. Expected words are queued per instance as stimulus is driven and are
// popped whenever a word is transferred.
// -----------------------------------------------------------------------------
module tb_demux_widen_param;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } expWord_t;

    logic clk_4f = 1'b0;
    logic reset  = 1'b0;

    always #5 clk_4f = ~clk_4f;

    logic [7:0]  dIn8  = '0;
    logic        vIn8  = 1'b0;
    logic        rdy8  = 1'b1;
    logic [15:0] dIn16 = '0;
    logic        vIn16 = 1'b0;
    logic        rdy16 = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    expWord_t q0[$];
    expWord_t q1[$];
    expWord_t q2[$];
    expWord_t q3[$];
    expWord_t e0, e1, e2, e3;

    demux_widen_param_if #(.IN_W(8),  .RATIO(4)) if0 ();
    demux_widen_param_if #(.IN_W(8),  .RATIO(4)) if1 ();
    demux_widen_param_if #(.IN_W(8),  .RATIO(4)) if2 ();
    demux_widen_param_if #(.IN_W(16), .RATIO(2)) if3 ();

    assign if0.data_in = dIn8;  assign if0.valid_in = vIn8;  assign if0.out_ready = rdy8;
    assign if1.data_in = dIn8;  assign if1.valid_in = vIn8;  assign if1.out_ready = rdy8;
    assign if2.data_in = dIn8;  assign if2.valid_in = vIn8;  assign if2.out_ready = rdy8;
    assign if3.data_in = dIn16; assign if3.valid_in = vIn16; assign if3.out_ready = rdy16;

    demux_widen_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b1))
        u0 (.clk_4f(clk_4f), .reset(reset), .bus(if0));
    demux_widen_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .FLUSH_PARTIAL(1'b1))
        u1 (.clk_4f(clk_4f), .reset(reset), .bus(if1));
    demux_widen_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b0))
        u2 (.clk_4f(clk_4f), .reset(reset), .bus(if2));
    demux_widen_param #(.IN_W(16), .RATIO(2), .MSB_FIRST(1'b0), .FLUSH_PARTIAL(1'b1))
        u3 (.clk_4f(clk_4f), .reset(reset), .bus(if3));

    // Scoreboard pop side: a transfer happens on the next posedge whenever
    // valid_out and out_ready are both high at the preceding negedge.
    always @(negedge clk_4f) begin
        if (reset && if0.valid_out && if0.out_ready) begin
            compared++;
            if (q0.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL u0_word: got data=%h keep=%b, required no word", if0.data_out, if0.keep_out);
            end else begin
                e0 = q0.pop_front();
                if (if0.data_out !== e0.data || if0.keep_out !== e0.keep) begin
                    mismatched++;
                    $display("[TB] FAIL u0_word: got data=%h keep=%b, required data=%h keep=%b", if0.data_out, if0.keep_out, e0.data, e0.keep);
                end
            end
        end
    end

    always @(negedge clk_4f) begin
        if (reset && if1.valid_out && if1.out_ready) begin
            compared++;
            if (q1.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL u1_word: got data=%h keep=%b, required no word", if1.data_out, if1.keep_out);
            end else begin
                e1 = q1.pop_front();
                if (if1.data_out !== e1.data || if1.keep_out !== e1.keep) begin
                    mismatched++;
                    $display("[TB] FAIL u1_word: got data=%h keep=%b, required data=%h keep=%b", if1.data_out, if1.keep_out, e1.data, e1.keep);
                end
            end
        end
    end

    always @(negedge clk_4f) begin
        if (reset && if2.valid_out && if2.out_ready) begin
            compared++;
            if (q2.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL u2_word: got data=%h keep=%b, required no word", if2.data_out, if2.keep_out);
            end else begin
                e2 = q2.pop_front();
                if (if2.data_out !== e2.data || if2.keep_out !== e2.keep) begin
                    mismatched++;
                    $display("[TB] FAIL u2_word: got data=%h keep=%b, required data=%h keep=%b", if2.data_out, if2.keep_out, e2.data, e2.keep);
                end
            end
        end
    end

    always @(negedge clk_4f) begin
        if (reset && if3.valid_out && if3.out_ready) begin
            compared++;
            if (q3.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL u3_word: got data=%h keep=%b, required no word", if3.data_out, if3.keep_out);
            end else begin
                e3 = q3.pop_front();
                if (if3.data_out !== e3.data || {2'b00, if3.keep_out} !== e3.keep) begin
                    mismatched++;
                    $display("[TB] FAIL u3_word: got data=%h keep=%b, required data=%h keep=%b", if3.data_out, if3.keep_out, e3.data, e3.keep);
                end
            end
        end
    end

    // Drive one cycle on the shared 8-bit bus and return just after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        vIn8 = v;
        dIn8 = d;
        rdy8 = r;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic applyWide(input logic v, input logic [15:0] d, input logic r);
        vIn16 = v;
        dIn16 = d;
        rdy16 = r;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        compared++; if (if0.data_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_data_u0: got %h, required 00000000", if0.data_out); end
        compared++; if (if0.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid_u0: got %b, required 0", if0.valid_out); end
        compared++; if (if0.keep_out !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_keep_u0: got %b, required 0000", if0.keep_out); end
        compared++; if (if0.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ovf_u0: got %b, required 0", if0.overflow); end
        compared++; if (if1.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid_u1: got %b, required 0", if1.valid_out); end
        compared++; if (if3.data_out !== 32'h0 || if3.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_u3: got data=%h valid=%b, required 0/0", if3.data_out, if3.valid_out); end
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_full_words();
        q0.push_back('{32'hDDCCBBAA, 4'hF});
        q1.push_back('{32'hAABBCCDD, 4'hF});
        q2.push_back('{32'hDDCCBBAA, 4'hF});
        applyStimulus(1'b1, 8'hAA, 1'b1);
        applyStimulus(1'b1, 8'hBB, 1'b1);
        applyStimulus(1'b1, 8'hCC, 1'b1);
        compared++; if (if0.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL full_early_valid: got %b, required 0", if0.valid_out); end
        applyStimulus(1'b1, 8'hDD, 1'b1);
        compared++; if (if0.valid_out !== 1'b1 || if0.data_out !== 32'hDDCCBBAA || if0.keep_out !== 4'hF) begin mismatched++; $display("[TB] FAIL full_word_u0: got v=%b d=%h k=%b, required 1/DDCCBBAA/1111", if0.valid_out, if0.data_out, if0.keep_out); end
        compared++; if (if1.data_out !== 32'hAABBCCDD) begin mismatched++; $display("[TB] FAIL full_word_u1: got %h, required AABBCCDD", if1.data_out); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        compared++; if (if0.valid_out !== 1'b0 || if1.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL full_valid_drop: got u0=%b u1=%b, required 0/0", if0.valid_out, if1.valid_out); end
        compared++; if (q0.size() + q1.size() + q2.size() !== 0) begin mismatched++; $display("[TB] FAIL full_drain: got %0d pending, required 0", q0.size() + q1.size() + q2.size()); end
    endtask

    task automatic test_back_to_back();
        int pulses0;
        int pulses1;
        pulses0 = 0;
        pulses1 = 0;
        q0.push_back('{32'h04030201, 4'hF}); q0.push_back('{32'h08070605, 4'hF});
        q1.push_back('{32'h01020304, 4'hF}); q1.push_back('{32'h05060708, 4'hF});
        q2.push_back('{32'h04030201, 4'hF}); q2.push_back('{32'h08070605, 4'hF});
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) applyStimulus(1'b1, 8'(i), 1'b1);
            else        applyStimulus(1'b0, 8'h00, 1'b1);
            if (if0.valid_out === 1'b1) pulses0++;
            if (if1.valid_out === 1'b1) pulses1++;
        end
        compared++; if (pulses0 !== 2 || pulses1 !== 2) begin mismatched++; $display("[TB] FAIL b2b_pulses: got u0=%0d u1=%0d, required 2/2", pulses0, pulses1); end
        compared++; if (q0.size() + q1.size() + q2.size() !== 0) begin mismatched++; $display("[TB] FAIL b2b_drain: got %0d pending, required 0", q0.size() + q1.size() + q2.size()); end
    endtask

    task automatic test_partial_flush();
        q0.push_back('{32'h00002211, 4'b0011});
        q1.push_back('{32'h11220000, 4'b1100});
        applyStimulus(1'b1, 8'h11, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        compared++; if (if0.valid_out !== 1'b1 || if0.data_out !== 32'h00002211 || if0.keep_out !== 4'b0011) begin mismatched++; $display("[TB] FAIL flush_u0: got v=%b d=%h k=%b, required 1/00002211/0011", if0.valid_out, if0.data_out, if0.keep_out); end
        compared++; if (if1.keep_out !== 4'b1100) begin mismatched++; $display("[TB] FAIL flush_keep_u1: got %b, required 1100", if1.keep_out); end
        compared++; if (if2.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL discard_u2: got valid=%b, required 0", if2.valid_out); end
        q0.push_back('{32'hA4A3A2A1, 4'hF});
        q1.push_back('{32'hA1A2A3A4, 4'hF});
        q2.push_back('{32'hA4A3A2A1, 4'hF});
        applyStimulus(1'b1, 8'hA1, 1'b1);
        applyStimulus(1'b1, 8'hA2, 1'b1);
        applyStimulus(1'b1, 8'hA3, 1'b1);
        applyStimulus(1'b1, 8'hA4, 1'b1);
        compared++; if (if2.valid_out !== 1'b1 || if2.data_out !== 32'hA4A3A2A1) begin mismatched++; $display("[TB] FAIL discard_next_u2: got v=%b d=%h, required 1/A4A3A2A1", if2.valid_out, if2.data_out); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        compared++; if (q0.size() + q1.size() + q2.size() !== 0) begin mismatched++; $display("[TB] FAIL flush_drain: got %0d pending, required 0", q0.size() + q1.size() + q2.size()); end
    endtask

    task automatic test_backpressure();
        q0.push_back('{32'hB3B2B1B0, 4'hF});
        q1.push_back('{32'hB0B1B2B3, 4'hF});
        q2.push_back('{32'hB3B2B1B0, 4'hF});
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hB0 + i), 1'b0);
        compared++; if (if0.valid_out !== 1'b1 || if0.data_out !== 32'hB3B2B1B0) begin mismatched++; $display("[TB] FAIL bp_first_u0: got v=%b d=%h, required 1/B3B2B1B0", if0.valid_out, if0.data_out); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
            compared++; if (if0.data_out !== 32'hB3B2B1B0 || if0.keep_out !== 4'hF || if0.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_stable: got d=%h k=%b ovf=%b, required B3B2B1B0/1111/0", if0.data_out, if0.keep_out, if0.overflow); end
        end
        applyStimulus(1'b1, 8'hC3, 1'b0);
        compared++; if (if0.overflow !== 1'b1 || if1.overflow !== 1'b1 || if2.overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ovf_pulse: got u0=%b u1=%b u2=%b, required 1/1/1", if0.overflow, if1.overflow, if2.overflow); end
        compared++; if (if0.data_out !== 32'hB3B2B1B0) begin mismatched++; $display("[TB] FAIL bp_kept: got %h, required B3B2B1B0", if0.data_out); end
        applyStimulus(1'b0, 8'h00, 1'b0);
        compared++; if (if0.overflow !== 1'b0 || if0.valid_out !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ovf_end: got ovf=%b v=%b, required 0/1", if0.overflow, if0.valid_out); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        compared++; if (if0.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_release: got valid=%b, required 0", if0.valid_out); end
        compared++; if (q0.size() + q1.size() + q2.size() !== 0) begin mismatched++; $display("[TB] FAIL bp_drain: got %0d pending, required 0", q0.size() + q1.size() + q2.size()); end
    endtask

    task automatic test_load_with_transfer();
        q0.push_back('{32'hD3D2D1D0, 4'hF}); q0.push_back('{32'hE3E2E1E0, 4'hF});
        q1.push_back('{32'hD0D1D2D3, 4'hF}); q1.push_back('{32'hE0E1E2E3, 4'hF});
        q2.push_back('{32'hD3D2D1D0, 4'hF}); q2.push_back('{32'hE3E2E1E0, 4'hF});
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hD0 + i), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hE0 + i), 1'b0);
        applyStimulus(1'b1, 8'hE3, 1'b1);
        compared++; if (if0.valid_out !== 1'b1 || if0.overflow !== 1'b0 || if0.data_out !== 32'hE3E2E1E0) begin mismatched++; $display("[TB] FAIL lwt_u0: got v=%b ovf=%b d=%h, required 1/0/E3E2E1E0", if0.valid_out, if0.overflow, if0.data_out); end
        compared++; if (if1.data_out !== 32'hE0E1E2E3) begin mismatched++; $display("[TB] FAIL lwt_u1: got %h, required E0E1E2E3", if1.data_out); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        compared++; if (q0.size() + q1.size() + q2.size() !== 0) begin mismatched++; $display("[TB] FAIL lwt_drain: got %0d pending, required 0", q0.size() + q1.size() + q2.size()); end
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
        applyStimulus(1'b1, 8'hF0, 1'b0);
        applyStimulus(1'b1, 8'hF1, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        compared++; if (if0.data_out !== 32'h0 || if0.valid_out !== 1'b0 || if0.keep_out !== 4'h0 || if0.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_u0: got d=%h v=%b k=%b ovf=%b, required all 0", if0.data_out, if0.valid_out, if0.keep_out, if0.overflow); end
        compared++; if (if1.valid_out !== 1'b0 || if1.data_out !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_mid_u1: got v=%b d=%h, required 0/0", if1.valid_out, if1.data_out); end
        reset = 1'b1;
        q0.push_back('{32'h24232221, 4'hF});
        q1.push_back('{32'h21222324, 4'hF});
        q2.push_back('{32'h24232221, 4'hF});
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b1);
        compared++; if (if0.valid_out !== 1'b1 || if0.data_out !== 32'h24232221) begin mismatched++; $display("[TB] FAIL rst_clean_u0: got v=%b d=%h, required 1/24232221", if0.valid_out, if0.data_out); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        compared++; if (q0.size() + q1.size() + q2.size() !== 0) begin mismatched++; $display("[TB] FAIL rst_drain: got %0d pending, required 0", q0.size() + q1.size() + q2.size()); end
    endtask

    task automatic test_wide();
        q3.push_back('{32'h22221111, 4'b0011});
        applyWide(1'b1, 16'h1111, 1'b1);
        applyWide(1'b1, 16'h2222, 1'b1);
        compared++; if (if3.valid_out !== 1'b1 || if3.data_out !== 32'h22221111 || if3.keep_out !== 2'b11) begin mismatched++; $display("[TB] FAIL wide_full: got v=%b d=%h k=%b, required 1/22221111/11", if3.valid_out, if3.data_out, if3.keep_out); end
        q3.push_back('{32'h00005555, 4'b0001});
        applyWide(1'b1, 16'h5555, 1'b1);
        applyWide(1'b0, 16'h0000, 1'b1);
        compared++; if (if3.valid_out !== 1'b1 || if3.data_out !== 32'h00005555 || if3.keep_out !== 2'b01) begin mismatched++; $display("[TB] FAIL wide_flush: got v=%b d=%h k=%b, required 1/00005555/01", if3.valid_out, if3.data_out, if3.keep_out); end
        applyWide(1'b1, 16'h3333, 1'b1);
        applyWide(1'b1, 16'h4444, 1'b0);
        applyWide(1'b1, 16'h6666, 1'b0);
        reset = 1'b0;
        applyWide(1'b0, 16'h0000, 1'b0);
        compared++; if (if3.valid_out !== 1'b0 || if3.data_out !== 32'h0 || if3.keep_out !== 2'b00) begin mismatched++; $display("[TB] FAIL wide_reset: got v=%b d=%h k=%b, required 0/0/0", if3.valid_out, if3.data_out, if3.keep_out); end
        reset = 1'b1;
        q3.push_back('{32'hBBBBAAAA, 4'b0011});
        applyWide(1'b1, 16'hAAAA, 1'b1);
        applyWide(1'b1, 16'hBBBB, 1'b1);
        compared++; if (if3.valid_out !== 1'b1 || if3.data_out !== 32'hBBBBAAAA) begin mismatched++; $display("[TB] FAIL wide_clean: got v=%b d=%h, required 1/BBBBAAAA", if3.valid_out, if3.data_out); end
        applyWide(1'b0, 16'h0000, 1'b1);
        compared++; if (q3.size() !== 0) begin mismatched++; $display("[TB] FAIL wide_drain: got %0d pending, required 0", q3.size()); end
    endtask

    initial begin
        $display("[TB] starting demux_widen_param bench");
        test_reset();
        test_full_words();
        test_back_to_back();
        test_partial_flush();
        test_backpressure();
        test_load_with_transfer();
        test_reset_mid_word();
        test_wide();
        applyStimulus(1'b0, 8'h00, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
